// File: rtl/elastic_alu_stage.sv
// elastic_alu_stage: multi-cycle ALU between a PE operand join and its output buffer
// Ports: clk/reset; in_data_a/b, in_valid, in_stop (join side); op, const_data (current context);
//        out_data, out_valid, out_stop (buffer side); mem_read_address/mem_read_data (sync load memory);
//        start_exec, ctx_max_id, ctx_index, ctx_advance (context sequencing).
module elastic_alu_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 16,
  parameter int OPERATION_BIT_LENGTH = 4,
  parameter int CONTEXT_SIZE_BIT_LENGTH = 3,
  parameter int ADD_CYCLE = 1,
  parameter int SUB_CYCLE = 1,
  parameter int MUL_CYCLE = 3,
  parameter int DIV_CYCLE = 8,
  parameter int CONST_CYCLE = 1,
  parameter int LOAD_CYCLE = 2,
  parameter int OUTPUT_CYCLE = 1,
  parameter int ROUTE_CYCLE = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_WIDTH-1:0]              in_data_a,
  input  logic [DATA_WIDTH-1:0]              in_data_b,
  input  logic                               in_valid,
  output logic                               in_stop,
  input  logic [OPERATION_BIT_LENGTH-1:0]    op,
  input  logic [DATA_WIDTH-1:0]              const_data,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_valid,
  input  logic                               out_stop,
  output logic [ADDRESS_WIDTH-1:0]           mem_read_address,
  input  logic [DATA_WIDTH-1:0]              mem_read_data,
  input  logic                               start_exec,
  input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx_max_id,
  output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] ctx_index,
  output logic                               ctx_advance
);
  localparam int OBL = OPERATION_BIT_LENGTH;
  localparam logic [OBL-1:0] OP_ADD = OBL'(1);
  localparam logic [OBL-1:0] OP_SUB = OBL'(2);
  localparam logic [OBL-1:0] OP_MUL = OBL'(3);
  localparam logic [OBL-1:0] OP_DIV = OBL'(4);
  localparam logic [OBL-1:0] OP_CONST = OBL'(5);
  localparam logic [OBL-1:0] OP_LOAD = OBL'(6);
  localparam logic [OBL-1:0] OP_OUTPUT = OBL'(7);
  localparam logic [OBL-1:0] OP_ROUTE = OBL'(8);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t state, next;
  logic [DATA_WIDTH-1:0] a_r, b_r, c_r;
  logic [OBL-1:0] op_r;
  logic [7:0] cnt, cyc_in;
  logic accept, out_xfer;
  function automatic logic [7:0] cycles(input logic [OBL-1:0] o);
    case (o)
      OP_ADD: return 8'(ADD_CYCLE);
      OP_SUB: return 8'(SUB_CYCLE);
      OP_MUL: return 8'(MUL_CYCLE);
      OP_DIV: return 8'(DIV_CYCLE);
      OP_CONST: return 8'(CONST_CYCLE);
      OP_LOAD: return 8'(LOAD_CYCLE);
      OP_OUTPUT: return 8'(OUTPUT_CYCLE);
      OP_ROUTE: return 8'(ROUTE_CYCLE);
      default: return 8'd1;
    endcase
  endfunction
  function automatic logic [DATA_WIDTH-1:0] alu(input logic [OBL-1:0] o,
      input logic [DATA_WIDTH-1:0] a, b, c, m);
    case (o)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_MUL: return a * b;
      OP_DIV: return b == '0 ? '1 : a / b;
      OP_CONST: return c;
      OP_LOAD: return m;
      OP_OUTPUT, OP_ROUTE: return a;
      default: return '0;
    endcase
  endfunction
  assign in_stop = !(state == IDLE || (state == HOLD && !out_stop));
  assign accept = in_valid && !in_stop;
  assign out_valid = state == HOLD;
  assign out_xfer = out_valid && !out_stop;
  assign cyc_in = cycles(op);
  always_comb begin
    next = state;
    next = accept ? (cyc_in == 8'd1 ? HOLD : EXEC)
         : (state == EXEC && cnt == 8'd1) ? HOLD
         : (state == HOLD && out_xfer) ? IDLE : state;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= '0;
      op_r <= '0;
      cnt <= '0;
      out_data <= '0;
      mem_read_address <= '0;
      ctx_index <= '0;
      ctx_advance <= 1'b0;
    end else begin
      if (accept) begin
        a_r <= in_data_a;
        b_r <= in_data_b;
        c_r <= const_data;
        op_r <= op;
        cnt <= cyc_in - 8'd1;
        if (op == OP_LOAD) mem_read_address <= in_data_a[ADDRESS_WIDTH-1:0];
        // single-cycle ops go straight to HOLD, so their result is formed from the live operands
        if (cyc_in == 8'd1) out_data <= alu(op, in_data_a, in_data_b, const_data, mem_read_data);
      end else if (state == EXEC) begin
        cnt <= cnt - 8'd1;
        if (cnt == 8'd1) out_data <= alu(op_r, a_r, b_r, c_r, mem_read_data);
      end
      ctx_advance <= out_xfer;
      ctx_index <= start_exec ? '0 : !out_xfer ? ctx_index : ctx_index == ctx_max_id ? '0 : ctx_index + 1'b1;
    end
  end
endmodule

// File: tb/tb_elastic_alu_stage.sv
// tb_elastic_alu_stage: directed bench with a result scoreboard for elastic_alu_stage
module tb_elastic_alu_stage;
  logic clk = 1'b0;
  logic reset, in_valid, in_stop, out_valid, out_stop, start_exec, ctx_advance;
  logic [31:0] in_data_a, in_data_b, const_data, out_data, mem_read_data;
  logic [3:0] op;
  logic [15:0] mem_read_address;
  logic [2:0] ctx_max_id, ctx_index;
  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  always #5 clk = ~clk;
  elastic_alu_stage dut (
    .clk(clk), .reset(reset), .in_data_a(in_data_a), .in_data_b(in_data_b),
    .in_valid(in_valid), .in_stop(in_stop), .op(op), .const_data(const_data),
    .out_data(out_data), .out_valid(out_valid), .out_stop(out_stop),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
    .start_exec(start_exec), .ctx_max_id(ctx_max_id), .ctx_index(ctx_index),
    .ctx_advance(ctx_advance)
  );
  function automatic logic [31:0] mem_fn(input logic [15:0] ad);
    return ad == 16'h0012 ? 32'h0000ABCD : {16'h5A5A, ad};
  endfunction
  assign mem_read_data = mem_fn(mem_read_address);
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, b, c);
    case (o)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a * b;
      4'd4: return b == 32'd0 ? 32'hFFFFFFFF : a / b;
      4'd5: return c;
      4'd6: return mem_fn(a[15:0]);
      4'd7, 4'd8: return a;
      default: return 32'd0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) sb.delete();
    else begin
      if (out_valid && !out_stop) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_output: observed %0h with empty scoreboard", out_data);
        end else chk("result", out_data, sb.pop_front());
      end
      if (in_valid && !in_stop) sb.push_back(model(op, in_data_a, in_data_b, const_data));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] o, input logic [31:0] a, b, c);
    op = o;
    in_data_a = a;
    in_data_b = b;
    const_data = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask
  task automatic wait_lat(input string tag, input int exp_lat);
    int n = 1;
    while (!out_valid && n <= 20) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'(exp_lat));
  endtask
  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] a, b, c, input int lat);
    issue(o, a, b, c);
    wait_lat(tag, lat);
    step();
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_stop = 1'b0;
    start_exec = 1'b0;
    ctx_max_id = 3'd7;
    op = 4'd0;
    in_data_a = 32'd0;
    in_data_b = 32'd0;
    const_data = 32'd0;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_mem_addr", 32'(mem_read_address), 32'd0);
    chk("rst_ctx_index", 32'(ctx_index), 32'd0);
    chk("rst_ctx_advance", 32'(ctx_advance), 32'd0);
    chk("rst_in_stop", 32'(in_stop), 32'd0);
    reset = 1'b0;
    step();
    issue(4'd1, 32'd5, 32'd7, 32'd0);
    wait_lat("add_latency", 1);
    chk("add_ctx_before", 32'(ctx_index), 32'd0);
    step();
    chk("add_ctx_after", 32'(ctx_index), 32'd1);
    chk("add_advance_pulse", 32'(ctx_advance), 32'd1);
    step();
    chk("add_advance_drop", 32'(ctx_advance), 32'd0);
    issue(4'd3, 32'h10000, 32'h10000, 32'd0);
    chk("mul_in_stop", 32'(in_stop), 32'd1);
    wait_lat("mul_latency", 3);
    step();
    run("div0_latency", 4'd4, 32'd9, 32'd0, 32'd0, 8);
    run("div_latency", 4'd4, 32'd9, 32'd2, 32'd0, 8);
    chk("ctx_after_div", 32'(ctx_index), 32'd4);
    out_stop = 1'b1;
    issue(4'd2, 32'd10, 32'd3, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", out_data, 32'd7);
      chk("stall_in_stop", 32'(in_stop), 32'd1);
      chk("stall_no_advance", 32'(ctx_advance), 32'd0);
      step();
    end
    out_stop = 1'b0;
    op = 4'd1;
    in_data_a = 32'd1;
    in_data_b = 32'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("b2b_out_valid", 32'(out_valid), 32'd1);
    chk("b2b_advance", 32'(ctx_advance), 32'd1);
    chk("b2b_ctx", 32'(ctx_index), 32'd5);
    step();
    issue(4'd6, 32'h0012, 32'd0, 32'd0);
    chk("load_address", 32'(mem_read_address), 32'h12);
    wait_lat("load_latency", 2);
    step();
    run("const_latency", 4'd5, 32'd1, 32'd2, 32'hC0FFEE, 1);
    run("route_latency", 4'd8, 32'h1234, 32'd9, 32'd0, 1);
    run("output_latency", 4'd7, 32'h55, 32'd9, 32'd0, 1);
    run("op12_latency", 4'd12, 32'h77, 32'd9, 32'd0, 1);
    chk("ctx_wrap7", 32'(ctx_index), 32'd3);
    ctx_max_id = 3'd2;
    start_exec = 1'b1;
    step();
    start_exec = 1'b0;
    chk("start_exec_idle", 32'(ctx_index), 32'd0);
    chk("start_exec_no_advance", 32'(ctx_advance), 32'd0);
    run("ctx_run1", 4'd1, 32'd1, 32'd1, 32'd0, 1);
    chk("ctx_seq1", 32'(ctx_index), 32'd1);
    run("ctx_run2", 4'd2, 32'd5, 32'd1, 32'd0, 1);
    chk("ctx_seq2", 32'(ctx_index), 32'd2);
    run("ctx_run3", 4'd1, 32'd3, 32'd3, 32'd0, 1);
    chk("ctx_seq_wrap", 32'(ctx_index), 32'd0);
    run("ctx_run4", 4'd1, 32'd4, 32'd4, 32'd0, 1);
    issue(4'd1, 32'd6, 32'd6, 32'd0);
    wait_lat("ctx_run5", 1);
    start_exec = 1'b1;
    step();
    start_exec = 1'b0;
    chk("start_exec_override", 32'(ctx_index), 32'd0);
    chk("start_exec_advance", 32'(ctx_advance), 32'd1);
    run("pre_reset_add", 4'd1, 32'd8, 32'd8, 32'd0, 1);
    issue(4'd4, 32'd100, 32'd3, 32'd0);
    step();
    step();
    chk("div_exec_in_stop", 32'(in_stop), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midop_reset_valid", 32'(out_valid), 32'd0);
    chk("midop_reset_ctx", 32'(ctx_index), 32'd0);
    chk("midop_reset_idle", 32'(in_stop), 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("no_output_after_reset", 32'(out_valid), 32'd0);
    run("post_reset_add", 4'd1, 32'd2, 32'd2, 32'd0, 1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
